lif_timestep_scheduler: RTL and testbench

Time-multiplexed scheduler for the leaky integrate-and-fire neuron datapath. It holds the membrane potential, input current and refractory state for `N_NEURONS` neurons, and sequences one shared leak/integrate/fire update per neuron per timestep. A timestep starts on a `tick_i` request and ends with a registered spike vector and a one-cycle `done_o` pulse. It sits between the stimulus/config interface and the spike output pins of the LIF design.

---
 rtl/lif_timestep_scheduler_if.sv | 29 ++
 rtl/lif_timestep_scheduler.sv | 78 +++++++
 tb/tb_lif_timestep_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lif_timestep_scheduler_if.sv
// lif_timestep_scheduler_if: stimulus/config inputs and spike/status outputs of the LIF scheduler
interface lif_timestep_scheduler_if #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH = 8,
  parameter int REFRAC_W = 2,
  localparam int IDX_W = $clog2(N_NEURONS)
);
  logic tick_i;
  logic cur_wr_en_i;
  logic [IDX_W-1:0] cur_wr_idx_i;
  logic [WIDTH-1:0] cur_wr_data_i;
  logic [WIDTH-1:0] thresh_i;
  logic [2:0] leak_shift_i;
  logic [REFRAC_W-1:0] refrac_i;
  logic [IDX_W-1:0] mem_rd_idx_i;
  logic [WIDTH-1:0] mem_rd_data_o;
  logic [N_NEURONS-1:0] spike_o;
  logic busy_o;
  logic done_o;
  logic overrun_o;
  modport master (
    output tick_i, cur_wr_en_i, cur_wr_idx_i, cur_wr_data_i, thresh_i, leak_shift_i, refrac_i, mem_rd_idx_i,
    input mem_rd_data_o, spike_o, busy_o, done_o, overrun_o
  );
  modport slave (
    input tick_i, cur_wr_en_i, cur_wr_idx_i, cur_wr_data_i, thresh_i, leak_shift_i, refrac_i, mem_rd_idx_i,
    output mem_rd_data_o, spike_o, busy_o, done_o, overrun_o
  );
endinterface

// File: rtl/lif_timestep_scheduler.sv
// lif_timestep_scheduler: sequences one shared leak/integrate/fire update per neuron per timestep
module lif_timestep_scheduler #(
  parameter int N_NEURONS = 4,
  parameter int WIDTH = 8,
  parameter int REFRAC_W = 2,
  localparam int IDX_W = $clog2(N_NEURONS)
) (
  input logic clk,
  input logic rst,
  lif_timestep_scheduler_if.slave bus
);
  typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;
  state_t state, state_n;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] v [N_NEURONS];
  logic [WIDTH-1:0] cur [N_NEURONS];
  logic [REFRAC_W-1:0] rc [N_NEURONS];
  logic [WIDTH-1:0] thr_s;
  logic [2:0] sh_s;
  logic [REFRAC_W-1:0] rf_s;
  logic [N_NEURONS-1:0] spk_sh, spk_nx, spike_q;
  logic overrun_q;
  logic [WIDTH-1:0] vl, sat;
  logic [WIDTH:0] sum;
  logic refr, fire, last;
  always_comb begin
    state_n = state == IDLE ? (bus.tick_i ? UPDATE : IDLE) : state == UPDATE ? (last ? DONE : UPDATE) : IDLE;
    vl = sh_s == 3'd0 ? v[idx] : v[idx] - (v[idx] >> sh_s);
    sum = {1'b0, vl} + {1'b0, cur[idx]};
    sat = sum[WIDTH] ? '1 : sum[WIDTH-1:0];
    refr = rc[idx] != '0;
    fire = !refr && sat >= thr_s;
    last = idx == IDX_W'(N_NEURONS - 1);
    spk_nx = spk_sh;
    spk_nx[idx] = fire;
  end
  assign bus.busy_o = state == UPDATE;
  assign bus.done_o = state == DONE;
  assign bus.spike_o = spike_q;
  assign bus.overrun_o = overrun_q;
  assign bus.mem_rd_data_o = 32'(bus.mem_rd_idx_i) < N_NEURONS ? v[bus.mem_rd_idx_i] : '0;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      thr_s <= '0;
      sh_s <= '0;
      rf_s <= '0;
      spk_sh <= '0;
      spike_q <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        v[i] <= '0;
        cur[i] <= '0;
        rc[i] <= '0;
      end
    end else begin
      state <= state_n;
      if (bus.tick_i && state != IDLE) overrun_q <= 1'b1;
      if (state == IDLE && bus.tick_i) begin
        idx <= '0;
        thr_s <= bus.thresh_i;
        sh_s <= bus.leak_shift_i;
        rf_s <= bus.refrac_i;
        spk_sh <= '0;
      end
      if (state == UPDATE) begin
        idx <= last ? '0 : idx + 1'b1;
        spk_sh <= spk_nx;
        v[idx] <= refr || fire ? '0 : sat;
        rc[idx] <= refr ? rc[idx] - 1'b1 : fire ? rf_s : rc[idx];
        if (last) spike_q <= spk_nx;
      end
      // the update above reads the pre-edge current, so a same-cycle write lands for the next step
      if (bus.cur_wr_en_i && 32'(bus.cur_wr_idx_i) < N_NEURONS) cur[bus.cur_wr_idx_i] <= bus.cur_wr_data_i;
    end
  end
endmodule

// File: tb/tb_lif_timestep_scheduler.sv
// tb_lif_timestep_scheduler: scenario and randomized checks against a behavioural neuron model
module tb_lif_timestep_scheduler;
  localparam int N = 4;
  localparam int W = 8;
  localparam int R = 2;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  lif_timestep_scheduler_if #(.N_NEURONS(N), .WIDTH(W), .REFRAC_W(R)) bus();
  lif_timestep_scheduler #(.N_NEURONS(N), .WIDTH(W), .REFRAC_W(R)) dut (.clk(clk), .rst(rst), .bus(bus));
  int vec = 0;
  int errs = 0;
  int mv[N];
  int mcur[N];
  int mrc[N];
  int thr, sh, rf;

  function automatic logic [N-1:0] m_step();
    logic [N-1:0] s;
    int vl, sm;
    s = '0;
    for (int i = 0; i < N; i++) begin
      vl = sh == 0 ? mv[i] : mv[i] - (mv[i] >> sh);
      sm = vl + mcur[i];
      if (sm > 255) sm = 255;
      if (mrc[i] != 0) begin
        mv[i] = 0;
        mrc[i] = mrc[i] - 1;
      end else if (sm >= thr) begin
        s[i] = 1'b1;
        mv[i] = 0;
        mrc[i] = rf;
      end else mv[i] = sm;
    end
    return s;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0;
      mcur[i] = 0;
      mrc[i] = 0;
    end
  endtask

  task automatic apply_rst();
    @(posedge clk) #1 rst = 1'b1;
    @(posedge clk) #1 rst = 1'b0;
    model_reset();
  endtask

  task automatic set_cfg(input int t, input int s, input int r);
    thr = t;
    sh = s;
    rf = r;
    bus.thresh_i = 8'(t);
    bus.leak_shift_i = 3'(s);
    bus.refrac_i = 2'(r);
  endtask

  task automatic wr_cur(input int i, input int d);
    @(posedge clk) #1;
    bus.cur_wr_en_i = 1'b1;
    bus.cur_wr_idx_i = 2'(i);
    bus.cur_wr_data_i = 8'(d);
    @(posedge clk) #1 bus.cur_wr_en_i = 1'b0;
    mcur[i] = d;
  endtask

  task automatic run_step(output logic [N-1:0] spk, output bit ok);
    ok = 1'b0;
    spk = '0;
    @(posedge clk) #1 bus.tick_i = 1'b1;
    @(posedge clk) #1 bus.tick_i = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done_o) begin
        ok = 1'b1;
        spk = bus.spike_o;
        break;
      end
      @(posedge clk) #1;
    end
    @(posedge clk) #1;
  endtask

  task automatic test_reset();
    logic [N-1:0] spk, e;
    bit ok;
    int nd;
    repeat (2) @(posedge clk);
    #1;
    vec++;
    if ({bus.busy_o, bus.done_o, bus.overrun_o, bus.spike_o} !== '0) begin
      errs++;
      $display("FAIL reset_init got=%b exp=0", {bus.busy_o, bus.done_o, bus.overrun_o, bus.spike_o});
    end
    rst = 1'b0;
    model_reset();
    set_cfg(255, 0, 0);
    for (int i = 0; i < N; i++) wr_cur(i, 20 + i);
    run_step(spk, ok);
    e = m_step();
    bus.mem_rd_idx_i = 2'd2;
    #1;
    vec++;
    if (!ok || spk !== e || bus.mem_rd_data_o !== 8'(mv[2])) begin
      errs++;
      $display("FAIL reset_pre ok=%0d spk=%b exp=%b v2=%0d exp=%0d", ok, spk, e, bus.mem_rd_data_o, mv[2]);
    end
    @(posedge clk) #1 bus.tick_i = 1'b1;
    @(posedge clk) #1;
    @(posedge clk) #1 bus.tick_i = 1'b0;
    vec++;
    if (bus.busy_o !== 1'b1 || bus.overrun_o !== 1'b1) begin
      errs++;
      $display("FAIL reset_midstep busy=%b overrun=%b exp=1,1", bus.busy_o, bus.overrun_o);
    end
    #3 rst = 1'b1;
    #1;
    vec++;
    if ({bus.busy_o, bus.done_o, bus.overrun_o, bus.spike_o, bus.mem_rd_data_o} !== '0) begin
      errs++;
      $display("FAIL reset_async busy=%b done=%b ovr=%b spk=%b v2=%0d exp all 0", bus.busy_o, bus.done_o,
               bus.overrun_o, bus.spike_o, bus.mem_rd_data_o);
    end
    @(posedge clk) #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) begin
      bus.mem_rd_idx_i = 2'(i);
      #1;
      vec++;
      if (bus.mem_rd_data_o !== '0) begin
        errs++;
        $display("FAIL reset_mem idx=%0d got=%0d exp=0", i, bus.mem_rd_data_o);
      end
    end
    nd = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk) #1;
      if (bus.done_o) nd++;
    end
    vec++;
    if (nd != 0 || bus.spike_o !== '0) begin
      errs++;
      $display("FAIL reset_nodone done_count=%0d spk=%b exp 0,0", nd, bus.spike_o);
    end
  endtask

  task automatic test_integration();
    logic [N-1:0] spk, e;
    bit ok;
    int ev;
    apply_rst();
    set_cfg(100, 0, 0);
    wr_cur(0, 30);
    for (int t = 1; t <= 4; t++) begin
      run_step(spk, ok);
      e = m_step();
      ev = t < 4 ? 30 * t : 0;
      bus.mem_rd_idx_i = 2'd0;
      #1;
      vec++;
      if (!ok || spk !== e || spk !== (t == 4 ? 4'b0001 : 4'b0000) || bus.mem_rd_data_o !== 8'(ev)) begin
        errs++;
        $display("FAIL integrate t=%0d ok=%0d spk=%b exp=%b v0=%0d exp=%0d", t, ok, spk, e, bus.mem_rd_data_o, ev);
      end
    end
  endtask

  task automatic test_leak();
    logic [N-1:0] spk, e;
    bit ok;
    int ev[3] = '{64, 32, 16};
    apply_rst();
    set_cfg(255, 1, 0);
    wr_cur(1, 64);
    for (int t = 0; t < 3; t++) begin
      run_step(spk, ok);
      e = m_step();
      if (t == 0) wr_cur(1, 0);
      bus.mem_rd_idx_i = 2'd1;
      #1;
      vec++;
      if (!ok || spk !== e || spk !== '0 || bus.mem_rd_data_o !== 8'(ev[t])) begin
        errs++;
        $display("FAIL leak t=%0d ok=%0d spk=%b v1=%0d exp=%0d", t, ok, spk, bus.mem_rd_data_o, ev[t]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [N-1:0] spk, e;
    bit ok;
    apply_rst();
    set_cfg(255, 0, 0);
    wr_cur(2, 200);
    for (int t = 1; t <= 2; t++) begin
      run_step(spk, ok);
      e = m_step();
      bus.mem_rd_idx_i = 2'd2;
      #1;
      vec++;
      if (!ok || spk !== e || spk !== (t == 2 ? 4'b0100 : 4'b0000) || bus.mem_rd_data_o !== (t == 1 ? 8'd200 : 8'd0)) begin
        errs++;
        $display("FAIL saturate t=%0d ok=%0d spk=%b exp=%b v2=%0d", t, ok, spk, e, bus.mem_rd_data_o);
      end
    end
  endtask

  task automatic test_refractory();
    logic [N-1:0] spk, e;
    bit ok;
    bit eb[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    apply_rst();
    set_cfg(50, 0, 2);
    wr_cur(3, 60);
    for (int t = 0; t < 4; t++) begin
      run_step(spk, ok);
      e = m_step();
      bus.mem_rd_idx_i = 2'd3;
      #1;
      vec++;
      if (!ok || spk !== e || spk[3] !== eb[t] || bus.mem_rd_data_o !== 8'(mv[3])) begin
        errs++;
        $display("FAIL refrac t=%0d ok=%0d spk=%b exp=%b v3=%0d exp=%0d", t, ok, spk, e, bus.mem_rd_data_o, mv[3]);
      end
    end
  endtask

  task automatic test_handshake();
    logic [N-1:0] spk, e;
    bit ok;
    int nb, nd, dpos;
    apply_rst();
    set_cfg(255, 0, 0);
    wr_cur(0, 5);
    wr_cur(1, 10);
    @(posedge clk) #1 bus.tick_i = 1'b1;
    @(posedge clk) #1 bus.tick_i = 1'b0;
    nb = 0;
    nd = 0;
    dpos = -1;
    for (int j = 0; j < 8; j++) begin
      if (bus.busy_o) nb++;
      if (bus.done_o) begin
        nd++;
        dpos = j;
      end
      if (j == 1) begin
        bus.tick_i = 1'b1;
        bus.thresh_i = 8'd0;
        bus.cur_wr_en_i = 1'b1;
        bus.cur_wr_idx_i = 2'd1;
        bus.cur_wr_data_i = 8'd50;
      end
      if (j == 2) begin
        bus.tick_i = 1'b0;
        bus.cur_wr_en_i = 1'b0;
      end
      @(posedge clk) #1;
    end
    e = m_step();
    mcur[1] = 50;
    vec++;
    if (nb != N || nd != 1 || dpos != N || bus.overrun_o !== 1'b1 || bus.spike_o !== e) begin
      errs++;
      $display("FAIL handshake busy=%0d done=%0d at=%0d ovr=%b spk=%b exp %0d,1,%0d,1,%b", nb, nd, dpos,
               bus.overrun_o, bus.spike_o, N, N, e);
    end
    bus.mem_rd_idx_i = 2'd1;
    #1;
    vec++;
    if (bus.mem_rd_data_o !== 8'(mv[1])) begin
      errs++;
      $display("FAIL samecycle_old v1=%0d exp=%0d", bus.mem_rd_data_o, mv[1]);
    end
    set_cfg(255, 0, 0);
    run_step(spk, ok);
    e = m_step();
    for (int i = 0; i < 2; i++) begin
      bus.mem_rd_idx_i = 2'(i);
      #1;
      vec++;
      if (!ok || spk !== e || bus.mem_rd_data_o !== 8'(mv[i]) || bus.overrun_o !== 1'b1) begin
        errs++;
        $display("FAIL samecycle_new idx=%0d ok=%0d v=%0d exp=%0d ovr=%b", i, ok, bus.mem_rd_data_o, mv[i], bus.overrun_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] s1, s2, e1, e2;
    int nd, p1, p2;
    apply_rst();
    set_cfg(40, 1, 1);
    for (int i = 0; i < N; i++) wr_cur(i, $urandom_range(0, 60));
    @(posedge clk) #1 bus.tick_i = 1'b1;
    @(posedge clk) #1;
    nd = 0;
    p1 = -1;
    p2 = -1;
    s1 = '0;
    s2 = '0;
    for (int j = 0; j < 12; j++) begin
      if (bus.done_o) begin
        nd++;
        if (p1 < 0) begin
          p1 = j;
          s1 = bus.spike_o;
        end else begin
          p2 = j;
          s2 = bus.spike_o;
        end
      end
      if (j == 11) bus.tick_i = 1'b0;
      @(posedge clk) #1;
    end
    e1 = m_step();
    e2 = m_step();
    vec++;
    if (nd != 2 || p1 != N || p2 != 2 * N + 2 || s1 !== e1 || s2 !== e2 || bus.overrun_o !== 1'b1) begin
      errs++;
      $display("FAIL back2back done=%0d at %0d,%0d spk=%b,%b exp=%b,%b ovr=%b", nd, p1, p2, s1, s2, e1, e2, bus.overrun_o);
    end
    for (int i = 0; i < N; i++) begin
      bus.mem_rd_idx_i = 2'(i);
      #1;
      vec++;
      if (bus.mem_rd_data_o !== 8'(mv[i])) begin
        errs++;
        $display("FAIL back2back_mem idx=%0d got=%0d exp=%0d", i, bus.mem_rd_data_o, mv[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [N-1:0] spk, e;
    bit ok;
    apply_rst();
    for (int t = 0; t < 15; t++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) wr_cur($urandom_range(0, N - 1), $urandom_range(0, 255));
      set_cfg($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 255), $urandom_range(0, 7), $urandom_range(0, 3));
      run_step(spk, ok);
      e = m_step();
      vec++;
      if (!ok || spk !== e) begin
        errs++;
        $display("FAIL random_spk t=%0d ok=%0d got=%b exp=%b", t, ok, spk, e);
      end
      for (int i = 0; i < N; i++) begin
        bus.mem_rd_idx_i = 2'(i);
        #1;
        vec++;
        if (bus.mem_rd_data_o !== 8'(mv[i])) begin
          errs++;
          $display("FAIL random_mem t=%0d idx=%0d got=%0d exp=%0d", t, i, bus.mem_rd_data_o, mv[i]);
        end
      end
    end
  endtask

  initial begin
    bus.tick_i = 1'b0;
    bus.cur_wr_en_i = 1'b0;
    bus.cur_wr_idx_i = '0;
    bus.cur_wr_data_i = '0;
    bus.thresh_i = '0;
    bus.leak_shift_i = '0;
    bus.refrac_i = '0;
    bus.mem_rd_idx_i = '0;
    thr = 0;
    sh = 0;
    rf = 0;
    model_reset();
    test_reset();
    test_integration();
    test_leak();
    test_saturation();
    test_refractory();
    test_handshake();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
